// File: rtl/voxel_wsched_pkg.sv
// Shared types for the voxel write scheduler: requester indices and the
// default-width write request record used by neighbouring blocks.
package voxel_wsched_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 64;

  // Requester index; REQ_NONE marks a cycle with no grant.
  typedef enum logic [1:0] {
    REQ_DBG  = 2'd0,
    REQ_EDIT = 2'd1,
    REQ_GEN  = 2'd2,
    REQ_NONE = 2'd3
  } req_e;

  // One voxel word write at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wreq_t;

endpackage

// File: rtl/voxel_wsched_starve_ctr.sv
// Saturating wait counter for one lower-priority requester. Counts cycles
// spent valid, eligible and not granted; promote_o is high once the count
// reaches LIMIT. Clears on grant or when valid drops; holds while ineligible.
module voxel_wsched_starve_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic eligible_i,
  input  logic granted_i,
  output logic promote_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, hold, or saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!valid_i || granted_i) begin
      cnt_d = '0;
    end else if (eligible_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign promote_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/voxel_write_scheduler.sv
// Arbitrates the single voxel_memory_64 write port among host debug, edit
// engine and world_gen writers. Edit writes are held off while a frame
// renders (when cfg_frame_gate is set) so a frame never sees mixed geometry.
// Optional build macro VOXEL_WSCHED_STARVE_GUARD_EN adds anti-starvation
// promotion for the edit and gen requesters.
//
// Handshake: a transfer happens in a cycle where valid && ready; ready is
// combinational from the current valids, at most one ready is high per
// cycle, and a requester must hold addr/data stable while valid && !ready.
module voxel_write_scheduler
  import voxel_wsched_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic              edit_valid,
  output logic              edit_ready,
  input  logic [ADDR_W-1:0] edit_addr,
  input  logic [DATA_W-1:0] edit_data,
  input  logic              gen_valid,
  output logic              gen_ready,
  input  logic [ADDR_W-1:0] gen_addr,
  input  logic [DATA_W-1:0] gen_data,
  input  logic              frame_busy,
  input  logic              cfg_frame_gate,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              hold_frame_start,
  output logic [CNT_W-1:0]  writes_committed,
  output logic              idle
);

  logic              edit_elig;
  logic              edit_promote;
  logic              gen_promote;
  req_e              grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              mem_write_en_q;
  logic [ADDR_W-1:0] mem_write_addr_q;
  logic [DATA_W-1:0] mem_write_data_q;
  logic [CNT_W-1:0]  writes_committed_q;

  // Edit is gated combinationally, so dropping the gate frees it same-cycle.
  assign edit_elig = !(cfg_frame_gate && frame_busy);

`ifdef VOXEL_WSCHED_STARVE_GUARD_EN
  voxel_wsched_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_edit_ctr (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (edit_valid),
    .eligible_i (edit_elig),
    .granted_i  (grant == REQ_EDIT),
    .promote_o  (edit_promote)
  );

  voxel_wsched_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_gen_ctr (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (gen_valid),
    .eligible_i (1'b1),
    .granted_i  (grant == REQ_GEN),
    .promote_o  (gen_promote)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign edit_promote = 1'b0;
  assign gen_promote  = 1'b0;
`endif

  // Grant selection: starved requesters first (edit before gen), then
  // fixed priority dbg > edit > gen. Nothing is granted during reset.
  always_comb begin
    grant = REQ_NONE;
    if (!rst) begin
      if (edit_promote && edit_valid && edit_elig) begin
        grant = REQ_EDIT;
      end else if (gen_promote && gen_valid) begin
        grant = REQ_GEN;
      end else if (dbg_valid) begin
        grant = REQ_DBG;
      end else if (edit_valid && edit_elig) begin
        grant = REQ_EDIT;
      end else if (gen_valid) begin
        grant = REQ_GEN;
      end
    end
  end

  // Address/data mux for the granted requester.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    case (grant)
      REQ_DBG: begin
        sel_addr = dbg_addr;
        sel_data = dbg_data;
      end
      REQ_EDIT: begin
        sel_addr = edit_addr;
        sel_data = edit_data;
      end
      REQ_GEN: begin
        sel_addr = gen_addr;
        sel_data = gen_data;
      end
      default: begin
        sel_addr = '0;
        sel_data = '0;
      end
    endcase
  end

  assign dbg_ready  = (grant == REQ_DBG);
  assign edit_ready = (grant == REQ_EDIT);
  assign gen_ready  = (grant == REQ_GEN);

  assign hold_frame_start = !rst && cfg_frame_gate && edit_valid && !edit_ready;

  // Output stage and committed-write counter; a reset drops any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_write_en_q     <= 1'b0;
      mem_write_addr_q   <= '0;
      mem_write_data_q   <= '0;
      writes_committed_q <= '0;
    end else begin
      mem_write_en_q <= (grant != REQ_NONE);
      if (grant != REQ_NONE) begin
        mem_write_addr_q   <= sel_addr;
        mem_write_data_q   <= sel_data;
        writes_committed_q <= writes_committed_q + CNT_W'(1);
      end
    end
  end

  assign mem_write_en     = mem_write_en_q;
  assign mem_write_addr   = mem_write_addr_q;
  assign mem_write_data   = mem_write_data_q;
  assign writes_committed = writes_committed_q;

  assign idle = !(dbg_valid || edit_valid || gen_valid) && !mem_write_en_q;

endmodule

// File: tb/tb_voxel_write_scheduler.sv
// Self-checking bench for voxel_write_scheduler. A reference arbiter model
// decides each cycle which requester should win; the expected memory write
// is queued and a monitor pops it when the DUT shows mem_write_en.
// A narrow counter width lets the random phase exercise counter wrap.
module tb_voxel_write_scheduler;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 64;
  localparam int LIMIT  = 16;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst;
  logic              dbg_valid, edit_valid, gen_valid;
  logic              dbg_ready, edit_ready, gen_ready;
  logic [ADDR_W-1:0] dbg_addr, edit_addr, gen_addr;
  logic [DATA_W-1:0] dbg_data, edit_data, gen_data;
  logic              frame_busy, cfg_frame_gate;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              hold_frame_start;
  logic [CNT_W-1:0]  writes_committed;
  logic              idle;

  voxel_write_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .edit_valid(edit_valid), .edit_ready(edit_ready), .edit_addr(edit_addr), .edit_data(edit_data),
    .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_addr(gen_addr), .gen_data(gen_data),
    .frame_busy(frame_busy), .cfg_frame_gate(cfg_frame_gate),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .hold_frame_start(hold_frame_start), .writes_committed(writes_committed), .idle(idle)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (actual=running required=done)");
    $fatal(1, "timeout");
  end

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [CNT_W-1:0]         model_cnt = '0;

  logic              v[3];
  logic [ADDR_W-1:0] a[3];
  logic [DATA_W-1:0] d[3];
  int                wt[3];
  logic              prev_granted = 1'b0;
  int                last_grant   = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbiter: which requester should be granted this cycle (-1 = none).
  function automatic int model_pick();
    logic edit_ok;
    edit_ok = !(cfg_frame_gate && frame_busy);
    if (rst) return -1;
`ifdef VOXEL_WSCHED_STARVE_GUARD_EN
    if (v[1] && edit_ok && wt[1] >= LIMIT) return 1;
    if (v[2] && wt[2] >= LIMIT) return 2;
`endif
    if (v[0]) return 0;
    if (v[1] && edit_ok) return 1;
    if (v[2]) return 2;
    return -1;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge: drive inputs, check combinational outputs against
  // the model, queue the expected write, advance to the next negedge.
  task automatic step();
    int   g;
    logic edit_ok;
    dbg_valid  = v[0]; dbg_addr  = a[0]; dbg_data  = d[0];
    edit_valid = v[1]; edit_addr = a[1]; edit_data = d[1];
    gen_valid  = v[2]; gen_addr  = a[2]; gen_data  = d[2];
    #1;
    edit_ok = !(cfg_frame_gate && frame_busy);
    g = model_pick();
    chk("dbg_ready",  64'(dbg_ready),  64'(g == 0));
    chk("edit_ready", 64'(edit_ready), 64'(g == 1));
    chk("gen_ready",  64'(gen_ready),  64'(g == 2));
    chk("hold_frame_start", 64'(hold_frame_start), 64'(!rst && cfg_frame_gate && v[1] && g != 1));
    chk("idle", 64'(idle), 64'(!(v[0] || v[1] || v[2]) && !prev_granted));
    for (int r = 1; r < 3; r++) begin
      if (rst || !v[r] || g == r) wt[r] = 0;
      else if (r == 1 && !edit_ok) wt[r] = wt[r];
      else if (wt[r] < LIMIT) wt[r] = wt[r] + 1;
    end
    if (g >= 0) begin
      exp_q.push_back({a[g], d[g]});
      v[g] = 1'b0;
    end
    prev_granted = (g >= 0);
    last_grant   = g;
    @(negedge clk);
  endtask

  task automatic offer(input int r, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    v[r] = 1'b1;
    a[r] = addr;
    d[r] = data;
  endtask

  task automatic clear_all();
    for (int r = 0; r < 3; r++) begin
      v[r] = 1'b0;
      wt[r] = 0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    #1;
    chk("mem_write_en", 64'(mem_write_en), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      model_cnt = model_cnt + 1'b1;
      if (mem_write_en) begin
        chk("mem_write_addr", 64'(mem_write_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("mem_write_data", mem_write_data, e[DATA_W-1:0]);
      end
    end
    chk("writes_committed", 64'(writes_committed), 64'(model_cnt));
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_gen;
    rst = 1'b1;
    cfg_frame_gate = 1'b0;
    frame_busy = 1'b0;
    for (int r = 0; r < 3; r++) begin
      a[r] = '0;
      d[r] = '0;
    end
    clear_all();
    @(negedge clk);

    // Reset state: requests present but nothing may be ready.
    cfg_frame_gate = 1'b1;
    offer(0, 18'h1, 64'h1);
    offer(1, 18'h2, 64'h2);
    step();
    chk("reset_mem_write_en", 64'(mem_write_en), 64'd0);
    chk("reset_mem_write_addr", 64'(mem_write_addr), 64'd0);
    chk("reset_mem_write_data", mem_write_data, 64'd0);
    chk("reset_writes_committed", 64'(writes_committed), 64'd0);
    clear_all();
    cfg_frame_gate = 1'b0;
    rst = 1'b0;
    step();

    // Single requester burst: gen writes addresses 0..3 back to back.
    for (int i = 0; i < 4; i++) begin
      offer(2, ADDR_W'(i), {$urandom, $urandom});
      step();
    end
    step();
    chk("gen_burst_count", 64'(writes_committed), 64'd4);

    // Collision: dbg beats edit, edit follows next cycle.
    offer(0, 18'h10, 64'hD0D0_0000_0000_0010);
    offer(1, 18'h20, 64'hEEEE_0000_0000_0020);
    step();
    chk("collision_first_grant", 64'(last_grant), 64'd0);
    step();
    chk("collision_second_grant", 64'(last_grant), 64'd1);
    step();

    // Gate: edit held while the frame renders, released when busy falls.
    cfg_frame_gate = 1'b1;
    frame_busy = 1'b1;
    offer(1, 18'h33, 64'h3333);
    for (int i = 0; i < 3; i++) step();
    frame_busy = 1'b0;
    step();
    chk("gate_release_grant", 64'(last_grant), 64'd1);
    step();
    cfg_frame_gate = 1'b0;

    // Starvation: dbg and gen both continuously valid.
    n_gen = 0;
    offer(2, 18'h2A, 64'h2A2A);
    for (int i = 0; i < 40; i++) begin
      if (!v[0]) offer(0, ADDR_W'($urandom), {$urandom, $urandom});
      step();
      if (last_grant == 2) begin
        n_gen++;
        offer(2, ADDR_W'($urandom), {$urandom, $urandom});
      end
    end
`ifdef VOXEL_WSCHED_STARVE_GUARD_EN
    chk("starve_gen_grants", 64'(n_gen), 64'd2);
`else
    chk("starve_gen_grants", 64'(n_gen), 64'd0);
`endif
    clear_all();
    v[2] = 1'b1;
    while (v[2]) step();
    step();

    // Reset mid-stream: a registered write is dropped immediately.
    offer(0, 18'h3FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    rst = 1'b1;
    #1;
    chk("midreset_mem_write_en", 64'(mem_write_en), 64'd0);
    chk("midreset_mem_write_addr", 64'(mem_write_addr), 64'd0);
    chk("midreset_mem_write_data", mem_write_data, 64'd0);
    chk("midreset_writes_committed", 64'(writes_committed), 64'd0);
    model_cnt = '0;
    prev_granted = 1'b0;
    clear_all();
    @(negedge clk);
    rst = 1'b0;
    offer(1, 18'h55, 64'h5555);
    step();
    step();
    chk("post_reset_count", 64'(writes_committed), 64'd1);

    // Random traffic, long enough to wrap the narrow counter.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 9) == 0) frame_busy = ~frame_busy;
      if ($urandom_range(0, 19) == 0) cfg_frame_gate = ~cfg_frame_gate;
      if (!v[0] && $urandom_range(0, 99) < 25) offer(0, ADDR_W'($urandom), {$urandom, $urandom});
      if (!v[1] && $urandom_range(0, 99) < 40) offer(1, ADDR_W'($urandom), {$urandom, $urandom});
      if (!v[2] && $urandom_range(0, 99) < 60) offer(2, ADDR_W'($urandom), {$urandom, $urandom});
      step();
    end

    // Drain and report.
    frame_busy = 1'b0;
    for (int i = 0; i < 40 && (v[0] || v[1] || v[2]); i++) step();
    step();
    step();
    chk("drained_requests", 64'(v[0] || v[1] || v[2]), 64'd0);
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
